// File: rtl/cp0_intc.sv
// cp0_intc: coprocessor-0 interrupt controller for the single-cycle MIPS core.
// Holds SR (IM/EXL/IE), Cause (IP), EPC and PRId. It synchronises six
// external interrupt lines and raises int_req to the next-PC unit.
module cp0_intc #(
  parameter logic [31:0] PRID = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  hw_int,
  input  logic [31:0] pc_next,
  input  logic [4:0]  cp0_addr,
  input  logic        cp0_we,
  input  logic [31:0] cp0_wdata,
  input  logic        eret,
  output logic [31:0] cp0_rdata,
  output logic        int_req,
  output logic [31:0] epc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // The exception-level bit is the state of a two-state machine.
  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  sync1_q, sync1_d;
  logic [5:0]  ip_q,    ip_d;
  logic [5:0]  im_q,    im_d;
  logic        ie_q,    ie_d;
  logic [31:0] epc_q,   epc_d;
  logic        exl_s;

  // The low PC bits are never stored: EPC is word aligned.
  logic        unused_pc_bits;
  assign unused_pc_bits = ^pc_next[1:0];

  assign exl_s = (state_q == HANDLER);

  // Interrupt decision from registered state only.
  always_comb begin
    int_req = ((|(ip_q & im_q)) & ie_q & ~exl_s);
  end

  // Next-state: entry beats MTC0; ERET clears EXL after any SR write.
  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    ie_d    = ie_q;
    epc_d   = epc_q;
    sync1_d = hw_int;
    ip_d    = sync1_q;
    if (int_req) begin
      epc_d   = {pc_next[31:2], 2'b00};
      state_d = HANDLER;
    end else begin
      if (cp0_we) begin
        case (cp0_addr)
          ADDR_SR: begin
            im_d    = cp0_wdata[15:10];
            ie_d    = cp0_wdata[0];
            state_d = cp0_wdata[1] ? HANDLER : NORMAL;
          end
          ADDR_EPC: begin
            epc_d = {cp0_wdata[31:2], 2'b00};
          end
          default: begin
            epc_d = epc_q;
          end
        endcase
      end else begin
        epc_d = epc_q;
      end
      if (eret) begin
        state_d = NORMAL;
      end else begin
        ie_d = ie_d;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= NORMAL;
      sync1_q <= 6'd0;
      ip_q    <= 6'd0;
      im_q    <= 6'd0;
      ie_q    <= 1'b0;
      epc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      ip_q    <= ip_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      epc_q   <= epc_d;
    end
  end

  // MFC0 read mux, combinational on the address, no write-through.
  always_comb begin
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'h0000, im_q, 8'h00, exl_s, ie_q};
      ADDR_CAUSE: cp0_rdata = {16'h0000, ip_q, 10'h000};
      ADDR_EPC:   cp0_rdata = epc_q;
      ADDR_PRID:  cp0_rdata = PRID;
      default:    cp0_rdata = 32'h0000_0000;
    endcase
  end

  assign epc = epc_q;

endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed bench for cp0_intc with a register-level model
// checked every cycle plus hand-computed literal expectations.
`timescale 1ns/100ps
module tb_cp0_intc;

  localparam logic [31:0] PRID_V = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic [5:0]  hw_int;
  logic [31:0] pc_next;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic        eret;
  logic [31:0] cp0_rdata;
  logic        int_req;
  logic [31:0] epc;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  cp0_intc #(.PRID(PRID_V)) dut (
    .clk(clk), .rst_n(rst_n), .hw_int(hw_int), .pc_next(pc_next),
    .cp0_addr(cp0_addr), .cp0_we(cp0_we), .cp0_wdata(cp0_wdata),
    .eret(eret), .cp0_rdata(cp0_rdata), .int_req(int_req), .epc(epc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: software-visible register images plus a two-deep line history.
  logic [31:0] m_sr, m_cause, m_epc;
  logic [5:0]  m_hist [2];

  function automatic logic m_req();
    logic [5:0] ip, im;
    ip = m_cause[15:10];
    im = m_sr[15:10];
    return ((ip & im) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd12) return m_sr;
    if (a == 5'd13) return m_cause;
    if (a == 5'd14) return m_epc;
    if (a == 5'd15) return PRID_V;
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    logic req;
    if (!rst_n) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
      m_hist[0] = 6'd0; m_hist[1] = 6'd0;
    end else begin
      req = m_req();
      m_hist[1] = m_hist[0];
      m_hist[0] = hw_int;
      if (req) begin
        m_epc = pc_next & 32'hFFFF_FFFC;
        m_sr  = m_sr | 32'h0000_0002;
      end else begin
        if (cp0_we && cp0_addr == 5'd12) m_sr  = cp0_wdata & 32'h0000_FC03;
        if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata & 32'hFFFF_FFFC;
        if (eret) m_sr = m_sr & ~32'h0000_0002;
      end
      m_cause = {16'd0, m_hist[1], 10'd0};
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_int_req", {31'd0, int_req}, {31'd0, m_req()});
      check("model_epc", epc, m_epc);
      check("model_rdata", cp0_rdata, m_read(cp0_addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    cp0_addr = a;
    #1;
    check(name, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
    step();
    cp0_we = 1'b0; cp0_wdata = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0; hw_int = 6'h3F; pc_next = 32'd0; cp0_addr = 5'd0;
    cp0_we = 1'b0; cp0_wdata = 32'd0; eret = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    // Reset state
    check("rst_int_req", {31'd0, int_req}, 32'd0);
    check("rst_epc", epc, 32'd0);
    rd(5'd12, 32'd0, "rst_sr");
    rd(5'd13, 32'd0, "rst_cause");
    rd(5'd14, 32'd0, "rst_epc_rd");
    rd(5'd15, 32'h0000_3000, "rst_prid");
    rst_n = 1'b1; hw_int = 6'd0;
    step();

    // Basic entry via IM0/IE
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, 32'h0000_0401, "sr_write");
    hw_int = 6'b000001; pc_next = 32'h0000_3010;
    step();
    rd(5'd13, 32'd0, "cause_1edge");
    check("req_1edge", {31'd0, int_req}, 32'd0);
    step();
    rd(5'd13, 32'h0000_0400, "cause_2edge");
    check("req_2edge", {31'd0, int_req}, 32'd1);
    step();
    check("req_one_cycle", {31'd0, int_req}, 32'd0);
    check("entry_epc", epc, 32'h0000_3010);
    rd(5'd12, 32'h0000_0403, "entry_sr");

    // ERET with line still high re-raises
    eret = 1'b1; pc_next = 32'h0000_3020;
    step();
    eret = 1'b0;
    check("eret_rereq", {31'd0, int_req}, 32'd1);
    step();
    check("reentry_epc", epc, 32'h0000_3020);

    // IM masking: only IM1 enabled while line 0 is high
    mtc0(5'd12, 32'h0000_0801);
    step();
    check("masked_req", {31'd0, int_req}, 32'd0);
    hw_int = 6'b000011;
    step();
    check("im1_1edge", {31'd0, int_req}, 32'd0);
    step();
    check("im1_2edge", {31'd0, int_req}, 32'd1);

    // Interrupt beats MTC0 of EPC
    pc_next = 32'h0000_3043;
    mtc0(5'd14, 32'h1234_5678);
    rd(5'd14, 32'h0000_3040, "int_beats_mtc0");
    rd(5'd12, 32'h0000_0803, "sr_after_entry2");

    // EPC alignment in NORMAL with IE=0
    mtc0(5'd12, 32'h0000_0000);
    mtc0(5'd14, 32'h0000_3007);
    rd(5'd14, 32'h0000_3004, "epc_align");
    check("ie0_no_req", {31'd0, int_req}, 32'd0);

    // Unmapped address ignores writes, reads 0
    mtc0(5'd5, 32'hFFFF_FFFF);
    rd(5'd5, 32'd0, "unmapped");

    // ERET together with MTC0 to SR: write lands, EXL forced clear
    eret = 1'b1;
    mtc0(5'd12, 32'hFFFF_FFFF);
    eret = 1'b0;
    rd(5'd12, 32'h0000_FC01, "eret_mtc0_sr");
    check("eret_mtc0_req", {31'd0, int_req}, 32'd1);
    pc_next = 32'h0000_4000;
    step();
    check("entry3_epc", epc, 32'h0000_4000);

    // Reset mid-handler with lines active
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rd(5'd12, 32'd0, "midrst_sr");
    rd(5'd13, 32'd0, "midrst_cause");
    check("midrst_req", {31'd0, int_req}, 32'd0);
    mtc0(5'd12, 32'h0000_0C01);
    check("resync_1edge", {31'd0, int_req}, 32'd0);
    step();
    check("resync_2edge", {31'd0, int_req}, 32'd1);
    step();
    hw_int = 6'd0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
